// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies with a half-width multiplier magnitude finish early.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  // state  | meaning
  // S_IDLE | accept start and MTHI/MTLO writes
  // S_CALC | one radix-2 multiply or divide iteration per cycle
  // S_FIX  | sign correction / divide-by-zero substitution into acc
  // S_DONE | load HI/LO from acc, pulse done on the way back to idle
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ITER_FULL = CNT_W'(XLEN);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     aux_q, aux_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;

  logic                sign_a, sign_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [CNT_W-1:0]    start_cnt;
  logic [XLEN:0]       rem_shift, diff;
  logic                q_bit;
  logic [XLEN-1:0]     new_rem;
  logic [XLEN-1:0]     quo, rem;

  assign sign_a = ~op[0] & a[XLEN-1];
  assign sign_b = ~op[0] & b[XLEN-1];
  assign mag_a  = sign_a ? -a : a;
  assign mag_b  = sign_b ? -b : b;

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [CNT_W-1:0] ITER_HALF = CNT_W'(XLEN / 2);
  assign start_cnt = (~op[1] && (mag_b[XLEN-1:XLEN/2] == '0)) ? ITER_HALF : ITER_FULL;
`else
  assign start_cnt = ITER_FULL;
`endif

  // Restoring divide step: acc holds {remainder, dividend/quotient}.
  assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, mcand_q[XLEN-1:0]};
  assign q_bit     = ~diff[XLEN];
  assign new_rem   = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];

  assign quo = acc_q[XLEN-1:0];
  assign rem = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    aux_d     = aux_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = start_cnt;
          is_div_d  = op[1];
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          dz_d      = op[1] & (b == '0);
          if (op[1]) begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            mcand_d = {{XLEN{1'b0}}, mag_b};
            aux_d   = a;  // raw dividend, returned in HI on divide by zero
          end else begin
            acc_d   = '0;
            mcand_d = {{XLEN{1'b0}}, mag_a};
            aux_d   = mag_b;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (is_div_q) begin
          acc_d = {new_rem, acc_q[XLEN-2:0], q_bit};
        end else begin
          // Multiplicand shifts left so an early stop leaves an aligned product.
          if (aux_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = {mcand_q[2*XLEN-2:0], 1'b0};
          aux_d   = {1'b0, aux_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_DONE;
        if (!is_div_q) begin
          acc_d = neg_q ? -acc_q : acc_q;
        end else if (dz_q) begin
          acc_d = {aux_q, {XLEN{1'b1}}};
        end else begin
          acc_d = {(neg_rem_q ? -rem : rem), (neg_q ? -quo : quo)};
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        hi_d    = acc_q[2*XLEN-1:XLEN];
        lo_d    = acc_q[XLEN-1:0];
        done_d  = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      aux_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      aux_q     <= aux_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
